// File: rtl/stack_ctrl.sv
// Instruction sequencer for the bit-sliced operand stack: accepts one opcode per handshake,
// checks it against the tracked depth and drives registered push/pop/swap/clear controls.
module stack_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           imm,
    input  logic [WIDTH-1:0]           tos,
    input  logic [WIDTH-1:0]           nos,
    output logic [WIDTH-1:0]           stk_d,
    output logic                       stk_en,
    output logic                       stk_dir,
    output logic                       stk_swp,
    output logic                       stk_clr,
    output logic [WIDTH-1:0]           result,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       err,
    output logic                       done
);
    localparam int DW = $clog2(DEPTH + 1);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_SWAP  = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_DUP   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        POP1 = 3'd2,
        POP2 = 3'd3,
        PUSH = 3'd4
    } state_t;

    state_t         state_r;
    logic           legal_s;
    logic           has_room_s;
    logic           has_one_s;
    logic           has_two_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;

    // Legality of the presented opcode against the current depth
    always_comb begin
        has_room_s = (depth < DW'(DEPTH));
        has_one_s  = (depth != {DW{1'b0}});
        has_two_s  = (depth >= DW'(2));
        sum_s      = nos + tos;
        diff_s     = nos - tos;
        legal_s    = 1'b1;
        case (op)
            OP_PUSH:                legal_s = has_room_s;
            OP_POP:                 legal_s = has_one_s;
            OP_DUP:                 legal_s = has_room_s && has_one_s;
            OP_SWAP, OP_ADD, OP_SUB: legal_s = has_two_s;
            default:                legal_s = 1'b1;
        endcase
    end

    // Sequencer state, registered stack controls, depth/err tracking and result hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            op_ready <= 1'b1;
            stk_d    <= {WIDTH{1'b0}};
            stk_en   <= 1'b0;
            stk_dir  <= 1'b0;
            stk_swp  <= 1'b0;
            stk_clr  <= 1'b0;
            result   <= {WIDTH{1'b0}};
            depth    <= {DW{1'b0}};
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            stk_d   <= {WIDTH{1'b0}};
            stk_en  <= 1'b0;
            stk_dir <= 1'b0;
            stk_swp <= 1'b0;
            stk_clr <= 1'b0;
            done    <= 1'b0;

            // depth follows the stack action that commits at this edge
            if (stk_clr) begin
                depth <= {DW{1'b0}};
                err   <= 1'b0;
            end else if (stk_en) begin
                depth <= stk_dir ? (depth + DW'(1)) : (depth - DW'(1));
            end

            case (state_r)
                IDLE: begin
                    if (op_valid) begin
                        op_ready <= 1'b0;
                        state_r  <= EXEC;
                        done     <= 1'b1;
                        if (!legal_s) begin
                            err <= 1'b1;
                        end else begin
                            case (op)
                                OP_PUSH: begin
                                    stk_en  <= 1'b1;
                                    stk_dir <= 1'b1;
                                    stk_d   <= imm;
                                end
                                OP_DUP: begin
                                    stk_en  <= 1'b1;
                                    stk_dir <= 1'b1;
                                    stk_d   <= tos;
                                end
                                OP_POP:   stk_en  <= 1'b1;
                                OP_SWAP:  stk_swp <= 1'b1;
                                OP_CLEAR: stk_clr <= 1'b1;
                                OP_ADD, OP_SUB: begin
                                    result  <= (op == OP_ADD) ? sum_s : diff_s;
                                    state_r <= POP1;
                                    stk_en  <= 1'b1;
                                    done    <= 1'b0;
                                end
                                default: stk_en <= 1'b0;
                            endcase
                        end
                    end
                end
                EXEC: begin
                    state_r  <= IDLE;
                    op_ready <= 1'b1;
                end
                POP1: begin
                    state_r <= POP2;
                    stk_en  <= 1'b1;
                end
                POP2: begin
                    state_r <= PUSH;
                    stk_en  <= 1'b1;
                    stk_dir <= 1'b1;
                    stk_d   <= result;
                    done    <= 1'b1;
                end
                PUSH: begin
                    state_r  <= IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state_r  <= IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Instruction sequencer that drives the bit-sliced operand stack of the stack calculator. It accepts one opcode at a time over a valid/ready handshake and reads the top two stack entries. It then emits per-cycle push/pop/swap/clear controls to the WIDTH stack bit-planes, each a DEPTH-entry shift register with entry 0 as top-of-stack. It also tracks stack depth, flags over/underflow, and holds the last arithmetic result for display.

## Interface
- WIDTH, 4, data width; also the number of stack bit-planes
- DEPTH, 8, entries per bit-plane (stack capacity)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- op_valid  in  1  opcode present
- op_ready  out  1  block can accept an opcode
- op  in  3  000 NOP, 001 PUSH, 010 POP, 011 SWAP, 100 ADD, 101 SUB, 110 DUP, 111 CLEAR
- imm  in  WIDTH  PUSH operand
- tos  in  WIDTH  stack entry 0, gathered as bit 0 of each plane
- nos  in  WIDTH  stack entry 1, gathered as bit 1 of each plane
- stk_d  out  WIDTH  serial-in data; bit i drives plane i
- stk_en  out  1  shift enable, common to all planes
- stk_dir  out  1  1 = push (shift toward deeper entries), 0 = pop (drop entry 0)
- stk_swp  out  1  swap entries 0 and 1
- stk_clr  out  1  synchronous clear of all planes
- result  out  WIDTH  last ADD/SUB result
- depth  out  $clog2(DEPTH+1)  current entry count
- err  out  1  sticky over/underflow flag
- done  out  1  one-cycle pulse when an opcode completes or is rejected

## Operation
- FSM states: IDLE, EXEC, POP1, POP2, PUSH. op_ready = (state == IDLE).
- Acceptance: an opcode is accepted at a rising edge with op_valid && op_ready. At that edge the block latches op, imm, tos and nos.
- Legality is checked at acceptance against depth:
  - PUSH and DUP need depth < DEPTH.
  - POP and DUP need depth ≥ 1.
  - SWAP, ADD and SUB need depth ≥ 2.
- Illegal opcode: err <= 1, no stk_* activity, depth unchanged. The FSM goes to EXEC and asserts done there.
- NOP: goes to EXEC and asserts done. No stk_* activity.
- EXEC for legal single-step opcodes (one cycle):
  - PUSH: stk_en=1, stk_dir=1, stk_d=imm, depth+1.
  - DUP: same as PUSH with stk_d = latched tos.
  - POP: stk_en=1, stk_dir=0, depth−1.
  - SWAP: stk_swp=1, stk_en=0.
  - CLEAR: stk_clr=1, depth <= 0, err <= 0. CLEAR is always legal.
- ADD/SUB path: IDLE → POP1 → POP2 → PUSH → IDLE.
  - POP1 and POP2 each pop once.
  - PUSH pushes the result with stk_d = result. result is computed from the latched operands.
  - ADD = nos + tos mod 2^WIDTH. SUB = nos − tos mod 2^WIDTH, with no borrow flag.
  - result register is loaded on the edge leaving IDLE.
  - Net depth change is −1.
- stk_* are registered. They are high for exactly the cycle the FSM spends in the corresponding state, and are 0 in IDLE.
- done is high during the final state (EXEC or PUSH).
- At most one of stk_en, stk_swp, stk_clr is high in any cycle.
- Reset (any time, including mid-sequence):
  - FSM returns to IDLE; depth=0, err=0, result=0, done=0, all stk_* = 0.
  - op_ready reads 1.
  - An in-flight ADD/SUB is abandoned and no partial push occurs. Stack contents are undefined until a CLEAR is issued.

## Timing
- Opcode accepted at edge N; stk_* are valid during cycle N..N+1; the stack updates at edge N+1.
- Single-step ops: op_ready low for exactly 1 cycle, high again after edge N+1. Back-to-back throughput is one opcode per 2 cycles.
- ADD/SUB:
  - Pops commit at edges N+1 and N+2; the push commits at edge N+3.
  - op_ready is low for 3 cycles.
  - result is valid from edge N+1.
  - depth updates on the same edge as the stack change it tracks.
- tos and nos are sampled only at acceptance. Changes on them during a sequence are ignored.
- op_valid held high with op_ready low has no effect. imm and op may change freely while op_ready is low.

## Test plan
- Reset, WIDTH=4, DEPTH=8; PUSH 3, PUSH 5, ADD → stk_* sequence pop, pop, push with stk_d=4'h8; depth 2→1; result=8; done high in the PUSH cycle.
- Stack holding tos=7, nos=2, then SUB → result 4'hB (wraps); depth −1; err stays 0.
- Nine PUSHes from empty → first eight succeed with depth=8; the ninth sets err=1, no stk_en, depth stays 8; a following CLEAR gives stk_clr for one cycle, depth=0, err=0.
- Empty stack, then POP, SWAP, ADD, DUP each → err=1, no stk_en/stk_swp, done pulses, depth stays 0.
- Two entries (tos=1, nos=6), then SWAP → stk_swp=1 for one cycle, stk_en=0, depth unchanged; then DUP → push with stk_d=6 (tos at acceptance after the swap).
- ADD accepted, rst asserted asynchronously during POP2 → all outputs 0 immediately; op_ready=1, depth=0 after release; no PUSH cycle is issued.
